// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX operand forwarding, load-use / branch stall-flush, MDU wait FSM.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             pc_src_ex,
    input  logic             mdu_op_ex,
    input  logic             mdu_done,
    input  logic [4:0]       rd_ma,
    input  logic [4:0]       rd_wb,
    input  logic             reg_write_ma,
    input  logic             reg_write_wb,
    output logic [1:0]       forward_a_ex,
    output logic [1:0]       forward_b_ex,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_ma,
    output logic             mdu_go,
    output logic             mdu_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_events,
`endif
    output logic             mdu_timeout_err
);

    // state    | meaning
    // ST_RUN   | normal issue; forwarding, load-use and branch handling active
    // ST_WAIT  | MDU op held in EX, whole front end frozen until done or timeout
    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    localparam int TMR_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MDU_TIMEOUT - 1);

    if (MDU_TIMEOUT < 2 || CNT_W < 1) begin : g_param_chk
        $error("hazard_ctrl: MDU_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_write_ma && rd_ma != 5'd0 && rd_ma == rs)
            return 2'b01;
        else if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = mem_read_ex && rd_ex != 5'd0 && (rd_ex == rs1_id || rd_ex == rs2_id);

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        err_d        = err_q;
        forward_a_ex = fwd_sel(rs1_ex);
        forward_b_ex = fwd_sel(rs2_ex);
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        flush_ma     = 1'b0;
        mdu_go       = 1'b0;
        mdu_busy     = (state_q == ST_WAIT);

        case (state_q)
            ST_RUN: begin
                if (mdu_op_ex) begin
                    mdu_go   = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    flush_ma = 1'b1;
                    tmr_d    = TMR_LOAD;
                    state_d  = ST_WAIT;
                end else if (pc_src_ex) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            ST_WAIT: begin
                // Terminal count marks the MDU_TIMEOUT-th wait cycle; stalls drop in that cycle.
                if (mdu_done) begin
                    state_d = ST_RUN;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    flush_ma = 1'b1;
                    tmr_d    = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (reset) begin
            forward_a_ex = 2'b00;
            forward_b_ex = 2'b00;
            stall_if     = 1'b0;
            stall_id     = 1'b0;
            stall_ex     = 1'b0;
            flush_id     = 1'b0;
            flush_ex     = 1'b0;
            flush_ma     = 1'b0;
            mdu_go       = 1'b0;
            mdu_busy     = 1'b0;
        end
    end

    assign mdu_timeout_err = err_q & ~reset;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_if && perf_stall_q != '1)
            perf_stall_d = perf_stall_q + CNT_W'(1);
        if ((flush_id || flush_ex || flush_ma) && perf_flush_q != '1)
            perf_flush_d = perf_flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q & {CNT_W{~reset}};
    assign perf_flush_events = perf_flush_q & {CNT_W{~reset}};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

endmodule
